cmd_tracker: RTL
================

# cmd_tracker

Parametrised outstanding-command tracker for the command/operand/done interface. Sits between the command source and the execution unit. Allocates a tag per accepted command and retires tags on `done`. Enforces in-order or out-of-order completion, a per-command timeout, and HLT drain semantics, and reports violations as sticky error bits.

## Interface
Parameters:
- `DEPTH`, 8: max outstanding commands; power of 2, ≥2. `TW = $clog2(DEPTH)`.
- `OPD_W`, 64: operand width.
- `TIMEOUT`, 64: max cycles from issue acceptance to done; ≥2.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `ooo_mode` in 1: 1 = completions in any order, 0 = in order.
- `iss_vld` in 1: command valid.
- `iss_cmd` in 3: `cmd_t`.
- `iss_opd1`, `iss_opd2` in OPD_W: operands. Forwarded registered.
- `iss_rdy` out 1: command accepted when `iss_vld && iss_rdy`.
- `iss_tag` out TW: tag assigned to the command; valid while `iss_rdy`.
- `exe_vld`, `exe_cmd`, `exe_tag`, `exe_opd1`, `exe_opd2` out: registered copy of the accepted command.
- `done_i` in 1: completion strobe.
- `done_tag` in TW: completing tag.
- `done_cmd_i` in 3: completing command type.
- `count` out `$clog2(DEPTH+1)`: outstanding commands.
- `halted` out 1: HLT retired; no further issue.
- `err` out 5: sticky errors. Bits: [0] unmatched, [1] cmd_mismatch, [2] order, [3] timeout, [4] dup_cmd.
- `err_clr` in 1: clears `err`.

## Operation
- State: per-tag `valid`, `cmd`, `age`. A `tag_fifo` holds tags in issue order. FSM is RUN / DRAIN / HALT.
- Reset values: all outputs 0, all entries invalid, FIFO empty, FSM in RUN, `ooo_mode` latch 0.
- `iss_rdy` is computed from registered state only:
  - RUN: `iss_rdy = count != DEPTH`, except `iss_cmd==HLT && count!=0` gives 0.
  - DRAIN and HALT: `iss_rdy = 0`.
- `iss_tag` is the lowest-index invalid tag.
- Acceptance of a non-HLT command:
  - Sets `valid[tag]`, stores `cmd`, sets `age=1`, pushes the tag into the FIFO.
  - Drives `exe_*` the next cycle. `exe_vld` is a 1-cycle pulse per acceptance.
- HLT handling:
  - Accepted only at `count==0`. Allocates no tag.
  - FSM goes RUN→HALT. `exe_vld` pulses with `exe_cmd=HLT`.
  - `iss_vld && iss_cmd==HLT && count!=0` in RUN: FSM goes RUN→DRAIN.
  - DRAIN→RUN when `count` reaches 0; the held HLT is then accepted normally.
- dup_cmd: acceptance whose `iss_cmd` equals the previously accepted cmd sets `err[4]`. The command is still accepted.
- Done processing, in priority order:
  - `!valid[done_tag]` → `err[0]`; no state change.
  - In-order mode with `done_tag != fifo_head` → `err[2]`; no retirement.
  - Otherwise retire: clear `valid`, pop the FIFO (in-order mode) or remove the tag from the FIFO (OOO mode).
  - On retirement, `done_cmd_i != stored cmd` → `err[1]`.
- `ooo_mode` is latched only on cycles with `count==0`. Changes while commands are outstanding take effect after drain.
- Timeout:
  - Valid entries increment `age` each cycle, saturating at `TIMEOUT`.
  - `err[3]` is set on the edge where any `age` reaches `TIMEOUT`. The entry stays valid.
- `err_clr` clears `err` on the next edge. A same-cycle new error wins.
- HALT exits only via `rst`.

## Timing
- Acceptance at edge N:
  - `count` increments at N.
  - `exe_*` are valid in cycle N+1.
  - The tag is unavailable for allocation from N+1.
- Done sampled at edge M: `count` decrement and `err` are visible after M.
- Issue and retire at the same edge:
  - `count` is unchanged.
  - A tag freed at M is allocatable from M+1 only; no same-cycle reuse.
- Full (`count==DEPTH`) with a done at M: `iss_rdy` rises in cycle M+1.
- Timeout: a command accepted at edge N and not retired sets `err[3]` at edge N+TIMEOUT-1.
- `rst` mid-operation: everything returns to reset values at the next edge. In-flight done strobes are ignored.

## Structure
- `gen_pkg`:
  - `typedef enum logic [2:0] cmd_t {RST, INIT, ADD, SUB, MULT, DIV, REM, HLT}`, encoded 0..7.
  - Error-bit index localparams `ERR_UNMATCHED..ERR_DUP`.
- Sub-module `tag_fifo` (DEPTH×TW):
  - Push, pop, and remove-by-value; the remove compacts entries.
  - Outputs head, empty, full.
- The FSM, tag allocator, age counters and error logic live in `cmd_tracker`.

## Test plan
- DEPTH=4, in-order. Issue ADD,SUB,MULT,DIV back-to-back → tags 0,1,2,3; `count=4`; `iss_rdy=0`. Done tag0/ADD → `count=3`; `iss_rdy=1` the next cycle; `err=0`.
- In-order. Issue ADD(t0),SUB(t1); done tag1 → `err[2]=1`, `count` stays 2. Switch to OOO after drain; repeat → no error; next issue gets tag1.
- Done tag2 while invalid → `err[0]`. Done tag0 with `done_cmd_i=DIV` for stored ADD → `err[1]`; tag retired.
- Issue INIT then HLT with `count=1` → DRAIN, `iss_rdy=0`. Done → `count=0`, HLT accepted, `halted=1`, `exe_cmd=HLT` pulse; later `iss_vld` ignored.
- TIMEOUT=8. Issue REM at edge N, no done → `err[3]` at edge N+7. `err_clr` → `err=0`.
- Issue SUB,SUB consecutively → `err[4]`. Assert `rst` mid-stream → `count=0`, `err=0`, `iss_tag=0`.

Source files
------------

// File: rtl/gen_pkg.sv
// Shared types for the command tracker: command encoding, FSM states and
// sticky error-bit positions.
package gen_pkg;

  typedef enum logic [2:0] {
    RST  = 3'd0,
    INIT = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    MULT = 3'd4,
    DIV  = 3'd5,
    REM  = 3'd6,
    HLT  = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } trk_state_t;

  localparam int ERR_UNMATCHED    = 0;
  localparam int ERR_CMD_MISMATCH = 1;
  localparam int ERR_ORDER        = 2;
  localparam int ERR_TIMEOUT      = 3;
  localparam int ERR_DUP          = 4;
  localparam int ERR_W            = 5;

endpackage

// File: rtl/tag_fifo.sv
// Issue-order tag list: push at tail, pop at head, or remove any tag by value
// with the entries behind it sliding down to keep the list compact.
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int TW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [TW-1:0] push_tag,
  input  logic          pop,
  input  logic          rm,
  input  logic [TW-1:0] rm_tag,
  output logic [TW-1:0] head,
  output logic          empty,
  output logic          full
);
  localparam int CW = $clog2(DEPTH+1);

  logic [TW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] w_mem [DEPTH];
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_pos;
  logic          w_del;

  always_comb begin
    w_del = pop | rm;
    w_pos = '0;
    if (rm) begin
      for (int i = DEPTH-1; i >= 0; i--)
        if (CW'(i) < r_cnt && r_mem[i] == rm_tag) w_pos = CW'(i);
    end
    w_mem = r_mem;
    if (w_del) begin
      for (int i = 0; i < DEPTH-1; i++)
        if (CW'(i) >= w_pos) w_mem[i] = r_mem[i+1];
    end
    w_cnt = r_cnt - CW'(w_del);
    // Push lands after the compaction so a same-cycle remove and push both apply.
    if (push) begin
      w_mem[w_cnt[TW-1:0]] = push_tag;
      w_cnt = w_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_mem <= '{default: '0};
    end else begin
      r_cnt <= w_cnt;
      r_mem <= w_mem;
    end
  end

  assign head  = r_mem[0];
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/cmd_tracker.sv
// Outstanding-command tracker: tag allocation, in-order/OOO retirement,
// per-tag timeout, HLT drain and sticky error reporting.
module cmd_tracker import gen_pkg::*; #(
  parameter  int DEPTH   = 8,
  parameter  int OPD_W   = 64,
  parameter  int TIMEOUT = 64,
  localparam int TW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH+1),
  localparam int AW      = $clog2(TIMEOUT+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ooo_mode,
  input  logic             iss_vld,
  input  cmd_t             iss_cmd,
  input  logic [OPD_W-1:0] iss_opd1,
  input  logic [OPD_W-1:0] iss_opd2,
  output logic             iss_rdy,
  output logic [TW-1:0]    iss_tag,
  output logic             exe_vld,
  output cmd_t             exe_cmd,
  output logic [TW-1:0]    exe_tag,
  output logic [OPD_W-1:0] exe_opd1,
  output logic [OPD_W-1:0] exe_opd2,
  input  logic             done_i,
  input  logic [TW-1:0]    done_tag,
  input  cmd_t             done_cmd_i,
  output logic [CW-1:0]    count,
  output logic             halted,
  output logic [ERR_W-1:0] err,
  input  logic             err_clr
);
  trk_state_t       r_state, w_nxt;
  logic [DEPTH-1:0] r_vld;
  cmd_t             r_cmd [DEPTH];
  logic [AW-1:0]    r_age [DEPTH];
  logic [CW-1:0]    r_count;
  logic [ERR_W-1:0] r_err;
  logic             r_ooo;
  cmd_t             r_last;
  logic             r_last_vld;

  logic             w_fire, w_acc, w_ret;
  logic [ERR_W-1:0] w_err;
  logic [TW-1:0]    w_head;
  logic             w_empty, w_full;

  tag_fifo #(.DEPTH(DEPTH), .TW(TW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_acc),
    .push_tag (iss_tag),
    .pop      (w_ret && !r_ooo),
    .rm       (w_ret && r_ooo),
    .rm_tag   (done_tag),
    .head     (w_head),
    .empty    (w_empty),
    .full     (w_full)
  );

  always_comb begin
    iss_tag = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_vld[i]) iss_tag = TW'(i);
  end

  always_comb begin
    w_nxt   = r_state;
    iss_rdy = 1'b0;
    case (r_state)
      S_RUN: begin
        // HLT is only taken on an empty tracker; otherwise hold it off and drain.
        iss_rdy = !w_full && !(iss_cmd == HLT && r_count != '0);
        if (iss_vld && iss_cmd == HLT) w_nxt = (r_count == '0) ? S_HALT : S_DRAIN;
      end
      S_DRAIN: if (r_count == '0) w_nxt = S_RUN;
      default: w_nxt = S_HALT;
    endcase
  end

  assign w_fire = iss_vld && iss_rdy;
  assign w_acc  = w_fire && iss_cmd != HLT;

  always_comb begin
    w_err = '0;
    w_ret = 1'b0;
    if (done_i) begin
      if (!r_vld[done_tag])                                  w_err[ERR_UNMATCHED] = 1'b1;
      else if (!r_ooo && (w_empty || done_tag != w_head))    w_err[ERR_ORDER]     = 1'b1;
      else begin
        w_ret = 1'b1;
        if (done_cmd_i != r_cmd[done_tag]) w_err[ERR_CMD_MISMATCH] = 1'b1;
      end
    end
    if (w_fire && r_last_vld && iss_cmd == r_last) w_err[ERR_DUP] = 1'b1;
    // Age saturates at TIMEOUT, so each entry can only flag once.
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i] && !(w_ret && done_tag == TW'(i)) && r_age[i] == AW'(TIMEOUT-1))
        w_err[ERR_TIMEOUT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_vld      <= '0;
      r_count    <= '0;
      r_err      <= '0;
      r_ooo      <= 1'b0;
      r_last     <= RST;
      r_last_vld <= 1'b0;
      exe_vld    <= 1'b0;
      exe_cmd    <= RST;
      exe_tag    <= '0;
      exe_opd1   <= '0;
      exe_opd2   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cmd[i] <= RST;
        r_age[i] <= '0;
      end
    end else begin
      r_state <= w_nxt;
      if (r_count == '0) r_ooo <= ooo_mode;
      r_count <= r_count + CW'(w_acc) - CW'(w_ret);
      r_err   <= (err_clr ? '0 : r_err) | w_err;
      exe_vld <= w_fire;
      if (w_fire) begin
        exe_cmd    <= iss_cmd;
        exe_tag    <= iss_tag;
        exe_opd1   <= iss_opd1;
        exe_opd2   <= iss_opd2;
        r_last     <= iss_cmd;
        r_last_vld <= 1'b1;
      end
      for (int i = 0; i < DEPTH; i++)
        if (r_vld[i] && r_age[i] != AW'(TIMEOUT)) r_age[i] <= r_age[i] + AW'(1);
      if (w_ret) r_vld[done_tag] <= 1'b0;
      if (w_acc) begin
        r_vld[iss_tag] <= 1'b1;
        r_cmd[iss_tag] <= iss_cmd;
        r_age[iss_tag] <= AW'(1);
      end
    end
  end

  assign count  = r_count;
  assign err    = r_err;
  assign halted = (r_state == S_HALT);

endmodule
